// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter slice: default sizes and
// a log2 helper that never returns a zero-width index.
package arb_pkg;

    localparam int ARB_DEF_N_REQ = 32'sd4;
    localparam int ARB_DEF_DW    = 32'sd8;

    // Index width for n entries; at least one bit even for a single entry
    function automatic int clog2_safe(input int n);
        int r;
        int p;
        r = 32'sd1;
        p = 32'sd2;
        while (p < n) begin
            p = p * 32'sd2;
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: rotate requests so the pointer sits at
// bit 0, take the lowest set bit, then rotate the grant back.
module rr_picker
    import arb_pkg::*;
#(
    parameter  int N_REQ = ARB_DEF_N_REQ,
    localparam int SW    = clog2_safe(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [SW-1:0]    gnt_idx,
    output logic             any_gnt
);

    logic [2*N_REQ-1:0] req_dbl_s;
    logic [2*N_REQ-1:0] gnt_dbl_s;
    logic [N_REQ-1:0]   req_rot_s;
    logic [N_REQ-1:0]   gnt_rot_s;
    logic [SW-1:0]      enc_s;
    logic [SW:0]        sum_s;

    // Rotate, priority-encode from the pointer upward, rotate back
    always_comb begin
        req_dbl_s = {req, req} >> ptr;
        req_rot_s = req_dbl_s[N_REQ-1:0];
        enc_s     = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot_s[j]) begin
                enc_s = SW'(j);
            end else begin
                enc_s = enc_s;
            end
        end
        gnt_rot_s = '0;
        if (|req_rot_s) begin
            gnt_rot_s[enc_s] = 1'b1;
        end else begin
            gnt_rot_s = '0;
        end
        // the upper half of the doubled vector holds the rotate-left result
        gnt_dbl_s  = {gnt_rot_s, gnt_rot_s} << ptr;
        gnt_onehot = gnt_dbl_s[2*N_REQ-1:N_REQ];
        sum_s      = {1'b0, enc_s} + {1'b0, ptr};
        if (sum_s >= (SW+1)'(N_REQ)) begin
            sum_s = sum_s - (SW+1)'(N_REQ);
        end else begin
            sum_s = sum_s;
        end
        gnt_idx = sum_s[SW-1:0];
        any_gnt = |req;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter feeding a one-deep registered output channel.
// Optional burst locking is enabled with RR_MUX_ARBITER_BURST_LOCK_EN.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ = ARB_DEF_N_REQ,
    parameter  int DW    = ARB_DEF_DW,
    localparam int SW    = clog2_safe(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    in_valid,
    input  logic [N_REQ*DW-1:0] in_data,
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
    input  logic [N_REQ-1:0]    in_last,
`endif
    output logic [N_REQ-1:0]    in_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic [SW-1:0]       out_src,
    input  logic                out_ready
);

    logic             out_valid_r;
    logic [DW-1:0]    out_data_r;
    logic [SW-1:0]    out_src_r;
    logic [SW-1:0]    ptr_r;
    logic             load_en_s;
    logic [N_REQ-1:0] gnt_onehot_s;
    logic [SW-1:0]    gnt_idx_s;
    logic             any_gnt_s;
    logic [N_REQ-1:0] in_ready_s;
    logic [SW-1:0]    win_idx_s;
    logic [SW-1:0]    ptr_next_s;
    logic [DW-1:0]    win_data_s;
    logic             xfer_s;
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
    logic             lock_r;
    logic [SW-1:0]    lock_idx_r;
`endif

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req        (in_valid),
        .ptr        (ptr_r),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (gnt_idx_s),
        .any_gnt    (any_gnt_s)
    );

    // Grant generation; rst_n gates in_ready so it drops without a clock
    always_comb begin
        load_en_s  = !out_valid_r || out_ready;
        in_ready_s = '0;
        win_idx_s  = gnt_idx_s;
        if (!rst_n) begin
            in_ready_s = '0;
        end
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
        else if (lock_r) begin
            win_idx_s = lock_idx_r;
            if (load_en_s) begin
                in_ready_s[lock_idx_r] = 1'b1;
            end else begin
                in_ready_s = '0;
            end
        end
`endif
        else if (load_en_s && any_gnt_s) begin
            in_ready_s = gnt_onehot_s;
        end else begin
            in_ready_s = '0;
        end
        xfer_s = in_valid[win_idx_s] && in_ready_s[win_idx_s];
        if (win_idx_s == SW'(N_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = win_idx_s + {{(SW-1){1'b0}}, 1'b1};
        end
    end

    // N:1 data mux steered by the winning index
    always_comb begin
        win_data_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx_s == SW'(i)) begin
                win_data_s = in_data[i*DW +: DW];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Output register, rotation pointer and optional burst lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= '0;
            ptr_r       <= '0;
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
            lock_r      <= 1'b0;
            lock_idx_r  <= '0;
`endif
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= win_data_s;
            out_src_r   <= win_idx_s;
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
            if (!in_last[win_idx_s]) begin
                lock_r     <= 1'b1;
                lock_idx_r <= win_idx_s;
            end else begin
                lock_r     <= 1'b0;
                ptr_r      <= ptr_next_s;
            end
`else
            ptr_r       <= ptr_next_s;
`endif
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural reference model.
module tb_rr_mux_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
    logic [3:0]  in_last;
`endif
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(.N_REQ(4), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic default_data();
        for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
    endtask

    typedef struct {
        logic [3:0] v;
        logic       rdy;
        logic [3:0] exp_ir;
        logic       exp_ov;
        logic [1:0] exp_src;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[16];

    // randomized stimulus state and reference model
    logic [3:0] cur_v;
    logic [7:0] cur_d[4];
    logic [3:0] cur_l;
    int  m_ptr;
    bit  m_ov;
    logic [7:0] m_data;
    int  m_src;
    bit  m_lock;
    int  m_lidx;
    int  win;
    bit  load;
    logic [3:0] exp_ir;

    initial begin
        // {in_valid, out_ready, in_ready, out_valid after edge, out_src, out_data}
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12};
        tbl[5]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
        tbl[6]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h11};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h11};
        tbl[9]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
        tbl[10] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h13};
        tbl[11] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tbl[12] = '{4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        tbl[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h11};
        tbl[15] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};

        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        default_data();
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
        in_last   = 4'b1111;
`endif
        #3;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_src", 32'(out_src), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 4'b0000;
        rst_n    = 1'b1;

        // vector table
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            in_valid  = tbl[r].v;
            out_ready = tbl[r].rdy;
            #1;
            chk($sformatf("tbl%0d in_ready", r), 32'(in_ready), 32'(tbl[r].exp_ir));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d out_valid", r), 32'(out_valid), 32'(tbl[r].exp_ov));
            if (tbl[r].exp_ov) begin
                chk($sformatf("tbl%0d out_src", r), 32'(out_src), 32'(tbl[r].exp_src));
                chk($sformatf("tbl%0d out_data", r), 32'(out_data), 32'(tbl[r].exp_data));
            end
        end

        // sparse request with wrap: pointer is 3, only requester 1 valid
        @(negedge clk);
        in_valid = 4'b0010;
        in_data[15:8] = 8'h5C;
        #1;
        chk("sparse in_ready", 32'(in_ready), 32'b0010);
        @(posedge clk);
        #1;
        chk("sparse out_data", 32'(out_data), 32'h5C);
        chk("sparse out_src", 32'(out_src), 32'd1);
        @(negedge clk);
        in_valid = 4'b0000;
        default_data();
        @(negedge clk);
        in_valid = 4'b1111;
        #1;
        chk("sparse ptr is 2", 32'(in_ready), 32'b0100);

        // reset in the middle of a stall holding 0xA5
        @(negedge clk);
        in_valid = 4'b0001;
        in_data[7:0] = 8'hA5;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("stall out_data", 32'(out_data), 32'hA5);
        chk("stall in_ready", 32'(in_ready), 32'd0);
        #2;
        in_valid = 4'b1111;
        rst_n    = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst out_data", 32'(out_data), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        default_data();
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        chk("post-reset grant", 32'(in_ready), 32'b0001);

        // full contention, always ready: 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("rr%0d out_src", k), 32'(out_src), 32'(k % 4));
            chk($sformatf("rr%0d out_data", k), 32'(out_data), 32'h10 + 32'(k % 4));
        end

`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
        // burst from requester 1 while requester 2 waits
        @(negedge clk);
        in_valid = 4'b0000;
        @(negedge clk);
        in_valid = 4'b0110;
        in_last  = 4'b1101;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) in_last = 4'b1111;
            if (b == 3) in_valid = 4'b0100;
            #1;
            chk($sformatf("burst%0d in_ready", b), 32'(in_ready), (b == 3) ? 32'b0100 : 32'b0010);
            @(posedge clk);
            #1;
            chk($sformatf("burst%0d out_src", b), 32'(out_src), (b == 3) ? 32'd2 : 32'd1);
            @(negedge clk);
        end
        in_last = 4'b1111;
`endif

        // randomized run against the reference model, from a fresh reset
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 4'b0000;
        @(negedge clk);
        rst_n  = 1'b1;
        cur_v  = 4'b0000;
        cur_l  = 4'b1111;
        m_ptr  = 0;
        m_ov   = 1'b0;
        m_data = 8'h00;
        m_src  = 0;
        m_lock = 1'b0;
        m_lidx = 0;
        for (int i = 0; i < 4; i++) cur_d[i] = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!cur_v[i] && $urandom_range(0, 2) != 0) begin
                    cur_v[i] = 1'b1;
                    cur_d[i] = 8'($urandom);
                    cur_l[i] = 1'($urandom_range(0, 1));
                end
                in_data[i*8 +: 8] = cur_d[i];
            end
            in_valid  = cur_v;
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
            in_last   = cur_l;
`endif
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            load = !m_ov || out_ready;
            win  = -1;
            if (m_lock) begin
                win = m_lidx;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (win < 0 && cur_v[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
                end
            end
            exp_ir = (win >= 0 && load) ? (4'b0001 << win) : 4'b0000;
            chk($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(exp_ir));
            chk($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                chk($sformatf("rnd%0d out_src", c), 32'(out_src), 32'(m_src));
                chk($sformatf("rnd%0d out_data", c), 32'(out_data), 32'(m_data));
            end
            if (win >= 0 && load && cur_v[win]) begin
                m_ov   = 1'b1;
                m_data = cur_d[win];
                m_src  = win;
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
                if (!cur_l[win]) begin
                    m_lock = 1'b1;
                    m_lidx = win;
                end else begin
                    m_lock = 1'b0;
                    m_ptr  = (win + 1) % 4;
                end
`else
                m_ptr  = (win + 1) % 4;
`endif
                cur_v[win] = 1'b0;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one registered output channel between N_REQ requesters. It is the sequencing controller for the mux2-style shared datapath.
- Each requester presents data with a valid/ready handshake. The block picks one requester per cycle and steers its data through an N:1 mux into a one-deep output register.
- It drives a single valid/ready output port. It sits between multiple producer blocks and one shared consumer.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DW, 8, data width per requester
- SW, $clog2(N_REQ), width of source index (derived localparam; not overridable)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  N_REQ  per-requester valid
- in_data  input  N_REQ*DW  packed data; requester i occupies bits [i*DW +: DW]
- in_ready  output  N_REQ  per-requester ready, one-hot or zero
- out_valid  output  1  output register holds a beat
- out_data  output  DW  registered data
- out_src  output  SW  index of the requester that produced out_data
- out_ready  input  1  consumer accepts the beat

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: out_valid=0, out_data=0, out_src=0, rr pointer=0, in_ready=0.
- Reset mid-operation: any beat held in the output register is discarded. No partial state survives.
- Slot free: load_en = !out_valid || out_ready, evaluated combinationally.
- Arbitration:
  - Search in_valid starting at the rr pointer, ascending, wrapping from N_REQ-1 to 0.
  - The first asserted requester is the winner.
  - in_ready[winner] = load_en. All other in_ready bits are 0.
  - No winner means in_ready=0.
- A transfer on requester i occurs when in_valid[i] && in_ready[i] at a clock edge. On that edge:
  - out_data <= in_data[i]
  - out_src <= i
  - out_valid <= 1
  - pointer <= (i+1) mod N_REQ
- Pointer wrap: a winner of N_REQ-1 sets the pointer to 0.
- Output side:
  - If out_valid && out_ready and no new transfer occurs, out_valid <= 0.
  - Simultaneous accept and load is a pass-through: the new beat replaces the old one and out_valid stays 1. This sustains 1 beat/cycle.
- Stall: while out_valid && !out_ready, out_data and out_src are held stable, in_ready=0, and the pointer does not move.
- Latency: 1 cycle from an input transfer to out_valid.
- The pointer advances only on a transfer, never on idle cycles.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 transfers.
- Input rule: requesters must hold in_valid and data until in_ready. The arbiter does not check this.
- Combinational paths:
  - in_ready depends combinationally on in_valid and out_ready.
  - out_valid, out_data and out_src are driven purely from registers.

Optional Feature:
- Macro: RR_MUX_ARBITER_BURST_LOCK_EN.
- Defined:
  - Adds input port in_last[N_REQ].
  - After a transfer from requester i with in_last[i]=0, the grant locks to i: lock flag set, locked index = i.
  - While locked, arbitration is bypassed. in_ready[i] = load_en only. The pointer is unchanged until the transfer with in_last[i]=1.
  - That final transfer clears the lock and sets pointer <= (i+1) mod N_REQ.
  - A locked requester that drops in_valid stalls the channel. No other requester is granted.
  - Reset clears the lock.
- Undefined: no in_last port, no lock register, and every beat re-arbitrates as described in Behaviour.

Decomposition:
- Shared package arb_pkg holds:
  - function clog2_safe, returning 1 for N_REQ=1
  - localparam defaults ARB_DEF_N_REQ=4 and ARB_DEF_DW=8
- One natural sub-module: rr_picker.
  - Purely combinational.
  - Inputs: req[N_REQ], ptr[SW]. Outputs: gnt_onehot[N_REQ], gnt_idx[SW], any_gnt.
  - Implemented by a rotate, priority-encode, rotate-back sequence.
- The top level holds the output register, the pointer register, the optional lock and the data mux.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-stall with out_valid=1, out_data=0xA5.
  - Required: out_valid=0, out_data=0 and in_ready=0 immediately, without waiting for a clock edge. After release, the first grant goes to requester 0.
- Full contention, always ready:
  - Stimulus: all 4 in_valid=1, in_data[i]=0x10+i, out_ready=1 for 8 cycles.
  - Required: out_src sequence 0,1,2,3,0,1,2,3. out_data tracks 0x10..0x13. out_valid=1 continuously from cycle 1.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after a beat from requester 2 (data 0x22).
  - Required: out_data=0x22 and out_src=2 held stable, in_ready=0. On out_ready=1 the next grant goes to requester 3.
- Sparse requests and wrap:
  - Stimulus: pointer=3, only requester 1 valid (data 0x5C).
  - Required: in_ready=4'b0010, out_data=0x5C next cycle, pointer becomes 2.
- Drain:
  - Stimulus: single beat, then in_valid=0 with out_ready=1.
  - Required: out_valid falls 1 cycle after acceptance. The pointer is unchanged while idle.
- Burst lock (macro defined):
  - Stimulus: requester 1 sends 3 beats with in_last=0,0,1 while requester 2 is continuously valid.
  - Required: out_src=1,1,1, then 2.
